lcd_write_ctrl: RTL

Parametrised character-LCD bus write sequencer, successor to the fixed 4-state E-strobe write cycle. Accepts one byte and an RS flag from the LCD command/init controller. Drives the LCD E/RS/DB pins with programmable setup, pulse, hold and post-write execution delays. Supports native 8-bit or 4-bit (two-nibble) bus mode, and signals completion with a one-cycle pulse.

---
 rtl/lcd_write_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lcd_write_ctrl.sv
// Character-LCD bus write sequencer: one byte per request, programmable
// setup/pulse/hold/gap timing, 8-bit or 4-bit (two-nibble) bus.
module lcd_write_ctrl #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 12,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned GAP_CYC     = 50,
    parameter bit          NIBBLE_MODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_enable,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_busy,
    output logic       wr_finish,
    output logic [2:0] state,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_db
);

    localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned MAX_CYC = (MAX_SP > MAX_HG) ? MAX_SP : MAX_HG;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam bit            HAS_GAP  = (GAP_CYC != 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nib_q, nib_d;
    logic [3:0]    lo_q, lo_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [7:0]    db_q, db_d;
    logic          fin_q, fin_d;
    logic          busy_q, busy_d;

    assign state     = state_q;
    assign lcd_e     = e_q;
    assign lcd_rs    = rs_q;
    assign lcd_db    = db_q;
    assign wr_finish = fin_q;
    assign wr_busy   = busy_q;

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nib_q   <= 1'b0;
            lo_q    <= 4'h0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            lo_q    <= lo_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic; counter reloads on every state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nib_d   = nib_q;
        lo_d    = lo_q;
        e_d     = e_q;
        rs_d    = rs_q;
        db_d    = db_q;
        fin_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_enable) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    nib_d   = 1'b0;
                    lo_d    = wr_data[3:0];
                    rs_d    = wr_rs;
                    db_d    = NIBBLE_MODE ? {wr_data[7:4], 4'h0} : wr_data;
                    e_d     = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                    e_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    e_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    if (NIBBLE_MODE && !nib_q) begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                        nib_d   = 1'b1;
                        db_d    = {lo_q, 4'h0};
                    end else if (HAS_GAP) begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        fin_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                e_d     = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
